inst_rom_loader: RTL

//   Instruction memory feeding the riscv core's fetch port (rom_addr_o/rom_ce_o in, rom_data_i out).

---
 rtl/inst_rom_loader_if.sv | 13 +
 rtl/inst_rom_loader.sv | 136 +++++++++++++
 2 files changed

// File: rtl/inst_rom_loader_if.sv
// Fetch port and loader byte stream of the instruction ROM loader.
// The master side is the core/loader environment; the slave side is the ROM.
interface inst_rom_loader_if;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst_o;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;

  modport master (output ce, addr, ld_valid, ld_data, input inst_o, ld_ready);
  modport slave  (input ce, addr, ld_valid, ld_data, output inst_o, ld_ready);
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM loaded from a checksummed byte stream; keeps the core in reset
// until the image verifies, then serves combinational fetches.
module inst_rom_loader #(
  parameter int          AW       = 10,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                clk,
  input  logic                rst_n,
  inst_rom_loader_if.slave    bus,
  input  logic                reload,
  output logic                core_rst_n,
  output logic                load_done,
  output logic                load_err,
  output logic [AW:0]         words_ld
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERROR} state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << AW;
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  state_t        state, state_next;
  logic [7:0]    n_lo;
  logic [AW:0]   n;
  logic [1:0]    byte_idx;
  logic [AW:0]   word_idx;
  logic [7:0]    csum;
  logic [23:0]   word_buf;

  logic          xfer;
  logic [15:0]   hdr;
  logic          hdr_big;
  logic          last_word;
  logic          mem_we;
  logic [AW-1:0] wa;
  logic          addr_high_zero;
  logic          addr_unused;

  logic [31:0]   mem [2**AW];

  assign xfer        = bus.ld_valid && bus.ld_ready;
  assign hdr         = {bus.ld_data, n_lo};
  assign hdr_big     = {1'b0, hdr} > CAPACITY;
  assign last_word   = (word_idx == n - ONE);
  assign mem_we      = (state == DATA) && xfer && (byte_idx == 2'd3);
  assign addr_unused = ^bus.addr[1:0];

  always_comb begin
    state_next = state;
    case (state)
      HDR0:  if (xfer) state_next = HDR1;
      HDR1:  if (xfer) state_next = hdr_big ? ERROR : ((hdr == 16'd0) ? CSUM : DATA);
      DATA:  if (xfer && byte_idx == 2'd3 && last_word) state_next = CSUM;
      CSUM:  if (xfer) state_next = (bus.ld_data == csum) ? RUN : ERROR;
      RUN:   if (reload) state_next = HDR0;
      ERROR: state_next = ERROR;
      default: state_next = HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HDR0;
      bus.ld_ready <= 1'b0;
      core_rst_n   <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_ld     <= '0;
      n_lo         <= '0;
      n            <= '0;
      byte_idx     <= '0;
      word_idx     <= '0;
      csum         <= '0;
      word_buf     <= '0;
    end else begin
      state        <= state_next;
      // Ready follows the state we are about to be in, so it drops on the edge leaving CSUM.
      bus.ld_ready <= (state_next == HDR0) || (state_next == HDR1) ||
                      (state_next == DATA) || (state_next == CSUM);
      case (state)
        HDR0: if (xfer) n_lo <= bus.ld_data;
        HDR1: if (xfer) begin
          word_idx <= '0;
          byte_idx <= '0;
          csum     <= '0;
          if (!hdr_big) begin
            n        <= hdr[AW:0];
            words_ld <= hdr[AW:0];
          end
        end
        DATA: if (xfer) begin
          csum     <= csum ^ bus.ld_data;
          byte_idx <= byte_idx + 2'd1;
          case (byte_idx)
            2'd0:    word_buf[7:0]   <= bus.ld_data;
            2'd1:    word_buf[15:8]  <= bus.ld_data;
            2'd2:    word_buf[23:16] <= bus.ld_data;
            default: word_idx        <= word_idx + ONE;
          endcase
        end
        RUN: begin
          if (reload) begin
            core_rst_n <= 1'b0;
            load_done  <= 1'b0;
            words_ld   <= '0;
          end else begin
            core_rst_n <= 1'b1;
            load_done  <= 1'b1;
          end
        end
        ERROR: begin
          load_err   <= 1'b1;
          core_rst_n <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The top lane arrives with the write, so the word is assembled on the fly.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx[AW-1:0]] <= {bus.ld_data, word_buf};
  end

  assign wa             = bus.addr[AW+1:2];
  assign addr_high_zero = (bus.addr[31:AW+2] == '0);

  always_comb begin
    bus.inst_o = 32'h0;
    if (bus.ce) begin
      if (state != RUN || !addr_high_zero || {1'b0, wa} >= n) bus.inst_o = NOP_INST;
      else bus.inst_o = mem[wa];
    end
  end

endmodule
